// File: rtl/direction_accumulator.sv
// Sequential direction estimator: one peripheral mic per clock, accumulating
// the phase-weighted direction vector relative to the central mic.
module direction_accumulator #(
  parameter  int NUM_MICS    = 3,
  parameter  int PHASE_WIDTH = 16,
  parameter  int COORD_WIDTH = 16,
  parameter  int WRAP_PHASE  = 1,
  localparam int ACC_WIDTH   = PHASE_WIDTH + COORD_WIDTH + 2 + $clog2(NUM_MICS + 1)
) (
  input  logic                                        clk_in,
  input  logic                                        rst_n_in,
  input  logic                                        valid_in,
  output logic                                        ready_out,
  input  logic [PHASE_WIDTH-1:0]                      central_phase,
  input  logic [1:0][COORD_WIDTH-1:0]                 central_loc,
  input  logic [NUM_MICS-1:0][PHASE_WIDTH-1:0]        peripheral_phases,
  input  logic [NUM_MICS-1:0][1:0][COORD_WIDTH-1:0]   mic_locations,
  input  logic [NUM_MICS-1:0]                         mic_mask,
  output logic                                        valid_out,
  input  logic                                        ready_in,
  output logic signed [ACC_WIDTH-1:0]                 vector_x,
  output logic signed [ACC_WIDTH-1:0]                 vector_y,
  output logic [NUM_MICS-1:0][PHASE_WIDTH:0]          phase_differences
);

  localparam int P     = PHASE_WIDTH;
  localparam int C     = COORD_WIDTH;
  localparam int PW    = P + C + 2;
  localparam int IDX_W = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MICS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0]                    idx;
  logic [P-1:0]                        cphase_r;
  logic [1:0][C-1:0]                   cloc_r;
  logic [NUM_MICS-1:0][P-1:0]          pph_r;
  logic [NUM_MICS-1:0][1:0][C-1:0]     mloc_r;
  logic [NUM_MICS-1:0]                 mask_r;
  logic signed [ACC_WIDTH-1:0]         acc_x, acc_y;

  logic                                accept;
  logic                                last;
  logic [P-1:0]                        dmod;
  logic signed [P:0]                   d;
  logic signed [C:0]                   dx, dy;
  logic signed [PW-1:0]                px, py;
  logic signed [ACC_WIDTH-1:0]         sum_x, sum_y;

  assign accept = (state == IDLE) && ready_out && valid_in;
  assign last   = (idx == LAST_IDX);

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (last) state_nx = DONE;
      DONE:    if (ready_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-mic phase difference, offsets and masked products for entry idx
  always_comb begin
    dmod = pph_r[idx] - cphase_r;
    if (WRAP_PHASE != 0)
      d = {dmod[P-1], dmod};
    else
      d = $signed({1'b0, pph_r[idx]}) - $signed({1'b0, cphase_r});
    dx = $signed({mloc_r[idx][0][C-1], mloc_r[idx][0]}) - $signed({cloc_r[0][C-1], cloc_r[0]});
    dy = $signed({mloc_r[idx][1][C-1], mloc_r[idx][1]}) - $signed({cloc_r[1][C-1], cloc_r[1]});
    px = PW'(d) * PW'(dx);
    py = PW'(d) * PW'(dy);
    sum_x = acc_x;
    sum_y = acc_y;
    if (mask_r[idx]) begin
      sum_x = acc_x + ACC_WIDTH'(px);
      sum_y = acc_y + ACC_WIDTH'(py);
    end
  end

  // State register and registered handshake flags
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      ready_out <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nx;
      ready_out <= (state_nx == IDLE);
      valid_out <= (state_nx == DONE);
    end
  end

  // Snapshot capture, accumulation and result registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idx               <= '0;
      cphase_r          <= '0;
      cloc_r            <= '0;
      pph_r             <= '0;
      mloc_r            <= '0;
      mask_r            <= '0;
      acc_x             <= '0;
      acc_y             <= '0;
      vector_x          <= '0;
      vector_y          <= '0;
      phase_differences <= '0;
    end else if (accept) begin
      idx      <= '0;
      cphase_r <= central_phase;
      cloc_r   <= central_loc;
      pph_r    <= peripheral_phases;
      mloc_r   <= mic_locations;
      mask_r   <= mic_mask;
      acc_x    <= '0;
      acc_y    <= '0;
    end else if (state == CALC) begin
      phase_differences[idx] <= d;
      acc_x <= sum_x;
      acc_y <= sum_y;
      if (last) begin
        idx      <= '0;
        vector_x <= sum_x;
        vector_y <= sum_y;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_direction_accumulator.sv
// Self-checking bench for direction_accumulator (wrapping and plain instances).
module tb_direction_accumulator;

  localparam int N  = 3;
  localparam int AW = 16 + 16 + 2 + $clog2(N + 1);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     valid_in;
  logic                     ready_in;
  logic [15:0]              cphase;
  logic [1:0][15:0]         cloc;
  logic [N-1:0][15:0]       pph;
  logic [N-1:0][1:0][15:0]  mloc;
  logic [N-1:0]             mask;

  logic                     ready_out, valid_out, ready_out_n, valid_out_n;
  logic signed [AW-1:0]     vx, vy, vx_n, vy_n;
  logic [N-1:0][16:0]       pd, pd_n;

  int errors = 0;
  int checks = 0;

  typedef struct {
    longint vx, vy, vxn, vyn;
    longint pd[N];
    longint pdn[N];
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  direction_accumulator #(.NUM_MICS(N), .PHASE_WIDTH(16), .COORD_WIDTH(16), .WRAP_PHASE(1)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .central_phase(cphase), .central_loc(cloc), .peripheral_phases(pph),
    .mic_locations(mloc), .mic_mask(mask), .valid_out(valid_out), .ready_in(ready_in),
    .vector_x(vx), .vector_y(vy), .phase_differences(pd)
  );

  direction_accumulator #(.NUM_MICS(N), .PHASE_WIDTH(16), .COORD_WIDTH(16), .WRAP_PHASE(0)) dut_nw (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(ready_out_n),
    .central_phase(cphase), .central_loc(cloc), .peripheral_phases(pph),
    .mic_locations(mloc), .mic_mask(mask), .valid_out(valid_out_n), .ready_in(ready_in),
    .vector_x(vx_n), .vector_y(vy_n), .phase_differences(pd_n)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: phase difference is the signed angular offset (wrap) or plain
  // subtraction; vector is the masked sum of difference times mic offset.
  function automatic exp_t model();
    exp_t e;
    int   raw, dw, dx, dy;
    e.vx = 0; e.vy = 0; e.vxn = 0; e.vyn = 0;
    for (int i = 0; i < N; i++) begin
      raw = int'(pph[i]) - int'(cphase);
      dw  = ((raw % 65536) + 65536) % 65536;
      if (dw >= 32768) dw -= 65536;
      dx = int'($signed(mloc[i][0])) - int'($signed(cloc[0]));
      dy = int'($signed(mloc[i][1])) - int'($signed(cloc[1]));
      e.pd[i]  = dw;
      e.pdn[i] = raw;
      if (mask[i]) begin
        e.vx  += longint'(dw) * dx;
        e.vy  += longint'(dw) * dy;
        e.vxn += longint'(raw) * dx;
        e.vyn += longint'(raw) * dy;
      end
    end
    return e;
  endfunction

  task automatic set_mic(input int i, input int ph, input int x, input int y);
    pph[i]     = 16'(ph);
    mloc[i][0] = 16'(x);
    mloc[i][1] = 16'(y);
  endtask

  task automatic scen1();
    cphase  = 16'h2000;
    cloc    = '0;
    set_mic(0, 'h3000, 100, 0);
    set_mic(1, 'h2000, 0, 100);
    set_mic(2, 'h1000, -100, 0);
    mask = 3'b111;
  endtask

  task automatic randomize_data();
    cphase  = 16'($urandom);
    cloc[0] = 16'($urandom);
    cloc[1] = 16'($urandom);
    for (int i = 0; i < N; i++) set_mic(i, int'($urandom), int'($urandom), int'($urandom));
    mask = 3'($urandom);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, longint'(ready_out), 0);
    chk({tag, "_valid"}, longint'(valid_out), 0);
    chk({tag, "_vx"}, vx, 0);
    chk({tag, "_vy"}, vy, 0);
    chk({tag, "_vxn"}, vx_n, 0);
    chk({tag, "_pd"}, longint'(pd), 0);
    chk({tag, "_pdn"}, longint'(pd_n), 0);
  endtask

  task automatic check_result(input string tag, input exp_t e);
    longint o;
    chk({tag, "_vx"}, vx, e.vx);
    chk({tag, "_vy"}, vy, e.vy);
    chk({tag, "_vxn"}, vx_n, e.vxn);
    chk({tag, "_vyn"}, vy_n, e.vyn);
    chk({tag, "_valid_n"}, longint'(valid_out_n), 1);
    for (int i = 0; i < N; i++) begin
      o = $signed(pd[i]);
      chk($sformatf("%s_pd%0d", tag, i), o, e.pd[i]);
      o = $signed(pd_n[i]);
      chk($sformatf("%s_pdn%0d", tag, i), o, e.pdn[i]);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!ready_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_timeout"}, longint'(ready_out), 1);
  endtask

  // One full transaction with exact latency checks and the output handshake.
  task automatic do_txn(input string tag);
    exp_t e;
    e = model();
    wait_ready(tag);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk({tag, "_lat0"}, longint'(valid_out), 0);
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      chk($sformatf("%s_lat%0d", tag, k), longint'(valid_out), (k == N) ? 1 : 0);
    end
    check_result(tag, e);
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    chk({tag, "_vo_drop"}, longint'(valid_out), 0);
    chk({tag, "_ro_rise"}, longint'(ready_out), 1);
  endtask

  initial begin
    exp_t   e, f;
    int     last_acc, accepts, n;
    bit     prev_vo, acc_last, pending;

    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    scen1();

    // Reset values, then ready_out on the first edge after release
    #1 check_reset("rst");
    #17 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_pre_edge", longint'(ready_out), 0);
    @(negedge clk);
    chk("ready_after_edge", longint'(ready_out), 1);

    // Basic vector
    scen1();
    do_txn("basic");
    chk("basic_vx_const", vx, 819200);
    chk("basic_pd0_const", longint'($signed(pd[0])), 4096);
    chk("basic_pd2_const", longint'($signed(pd[2])), -4096);

    // Wrap vs plain difference
    cphase = 16'h2000;
    cloc   = '0;
    set_mic(0, 'hF000, 1, 1);
    set_mic(1, 'h2000, 5, 7);
    set_mic(2, 'h2000, -3, 9);
    mask = 3'b111;
    do_txn("wrap");
    chk("wrap_vx_const", vx, -12288);
    chk("nowrap_vy_const", vy_n, 53248);

    // Masking
    scen1();
    mask = 3'b001;
    do_txn("mask1");
    chk("mask1_vx_const", vx, 409600);
    mask = 3'b000;
    do_txn("mask0");
    chk("mask0_vx_const", vx, 0);

    // Back-pressure with busy-time valid pulses
    scen1();
    e = model();
    wait_ready("bp");
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    randomize_data();
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    check_result("bp_done", e);
    for (int k = 0; k < 5; k++) begin
      randomize_data();
      valid_in = (k % 2 == 0);
      @(negedge clk);
      chk($sformatf("bp_hold_vo%0d", k), longint'(valid_out), 1);
      chk($sformatf("bp_hold_ro%0d", k), longint'(ready_out), 0);
      chk($sformatf("bp_hold_vx%0d", k), vx, e.vx);
      chk($sformatf("bp_hold_pd%0d", k), longint'($signed(pd[0])), e.pd[0]);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    chk("bp_vo_drop", longint'(valid_out), 0);
    chk("bp_ro_rise", longint'(ready_out), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_no_capture%0d", k), longint'(ready_out), 1);
    end

    // Asynchronous reset during the second CALC cycle
    scen1();
    wait_ready("rmid");
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("rmid");
    #7 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    scen1();
    do_txn("after_rst");
    chk("after_rst_vx_const", vx, 819200);

    // Randomised single transactions
    for (int t = 0; t < 12; t++) begin
      randomize_data();
      do_txn($sformatf("rnd%0d", t));
    end

    // Back-to-back with valid_in and ready_in held high
    wait_ready("b2b");
    ready_in = 1'b1;
    valid_in = 1'b1;
    randomize_data();
    last_acc = -1;
    accepts  = 0;
    prev_vo  = 1'b0;
    acc_last = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (valid_out) begin
        chk("b2b_pulse_width", longint'(prev_vo), 0);
        chk("b2b_queue", longint'(q.size() > 0), 1);
        if (q.size() > 0) begin
          f = q.pop_front();
          check_result("b2b", f);
        end
      end
      prev_vo = valid_out;
      if (acc_last) randomize_data();
      if (cyc == 45) valid_in = 1'b0;
      pending = ready_out && valid_in;
      if (pending) begin
        q.push_back(model());
        if (last_acc >= 0) chk("b2b_spacing", longint'(cyc - last_acc), 5);
        last_acc = cyc;
        accepts++;
      end
      acc_last = pending;
    end
    n = q.size();
    chk("b2b_drained", longint'(n), 0);
    chk("b2b_accepts", longint'(accepts), 9);
    ready_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/direction_accumulator.md
# direction_accumulator

Sequential, parametrised direction estimator for the microphone array. Accepts one snapshot of phases and coordinates for a central mic and NUM_MICS peripheral mics through a valid/ready handshake. Processes one peripheral mic per clock, reporting each phase difference and accumulating a phase-weighted direction vector (vector_x, vector_y). It sits between the per-mic phase extraction stage and the beam-steering/display logic, replacing the single-output combinational calculator.

## Interface

Parameters:
- NUM_MICS, 3: number of peripheral mics, ≥1.
- PHASE_WIDTH, 16: unsigned phase word width (P).
- COORD_WIDTH, 16: signed coordinate width (C).
- WRAP_PHASE, 1: 1 = phase differences wrap modulo 2^P; 0 = plain difference.
- Derived: ACC_WIDTH = P + C + 2 + $clog2(NUM_MICS+1).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk_in, input, 1: system clock, rising edge.
  - rst_n_in, input, 1: asynchronous active-low reset.
- Input handshake and snapshot:
  - valid_in, input, 1: snapshot valid.
  - ready_out, output, 1: block idle and able to accept a snapshot.
  - central_phase, input, P: central mic phase.
  - central_loc, input, 2×C signed: [0]=x, [1]=y.
  - peripheral_phases, input, NUM_MICS×P: peripheral phases.
  - mic_locations, input, NUM_MICS×2×C signed: per-mic x, y.
  - mic_mask, input, NUM_MICS: 1 = include the mic in the vector sum.
- Result and output handshake:
  - valid_out, output, 1: result valid.
  - ready_in, input, 1: downstream accepts the result.
  - vector_x, output, ACC_WIDTH signed: x component.
  - vector_y, output, ACC_WIDTH signed: y component.
  - phase_differences, output, NUM_MICS×(P+1) signed: per-mic differences.

## Operation

- States: IDLE, CALC, DONE.
- **IDLE**
  - ready_out=1.
  - On valid_in && ready_out: register all snapshot inputs and mic_mask, clear idx and both accumulators, go to CALC.
- **CALC** processes entry idx on each edge:
  - d = peripheral_phases[idx] − central_phase.
    - WRAP_PHASE=1: compute d as a P-bit modulo difference, interpret it as signed P bits, then sign-extend to P+1.
    - WRAP_PHASE=0: compute d as a (P+1)-bit signed difference.
  - dx = loc[idx].x − central.x and dy = loc[idx].y − central.y, each C+1 bits signed.
  - Write phase_differences[idx] = d.
  - If mask[idx]: acc_x += d·dx and acc_y += d·dy, with full-precision products sign-extended to ACC_WIDTH. No overflow is possible.
  - idx increments. When the edge processes idx == NUM_MICS−1, go to DONE and load vector_x and vector_y from the final sums.
- **DONE**
  - valid_out=1. All outputs are held stable until ready_in.
  - On ready_in: go to IDLE.
- Inputs are ignored whenever ready_out=0, and valid_in is not queued.
- A masked mic still reports its phase difference; only its vector contribution is zeroed.
- mic_mask == 0 gives vector_x = vector_y = 0.

## Timing

- All outputs are registered.
- Reset values: ready_out=0, valid_out=0, vector_x=0, vector_y=0, all phase_differences=0. Internal state: IDLE, idx=0.
- ready_out rises on the first rising edge after rst_n_in deasserts.
- Latency: with the snapshot accepted at edge E0, CALC occupies edges E1..E_NUM_MICS. valid_out is high immediately after edge E_NUM_MICS (3 cycles for NUM_MICS=3).
- The result transfers on an edge where valid_out && ready_in. After that edge valid_out=0 and ready_out=1. There is no same-cycle bypass.
  - Best-case throughput is one snapshot per NUM_MICS+2 cycles.
- phase_differences[i] updates on edge E(i+1). Consumers must sample it only while valid_out=1.
- Reset asserted in any state (mid-CALC, DONE with back-pressure) immediately forces all reset values, and the partial result is discarded.
- NUM_MICS=1: the CALC state lasts exactly one edge.

## Test plan

Defaults apply (NUM_MICS=3, P=C=16) unless stated.

1. **Basic vector.** WRAP=1, mask=3'b111, central 0x2000 at (0,0). Peripherals 0x3000 @(100,0), 0x2000 @(0,100), 0x1000 @(−100,0).
   - phase_differences = {4096, 0, −4096}.
   - vector_x = 819200, vector_y = 0.
   - valid_out rises 3 cycles after acceptance.
2. **Wrap mode.** Central 0x2000 @(0,0). Peripheral 0 = 0xF000 @(1,1); others = 0x2000.
   - WRAP=1: d0 = −12288, vector_x = vector_y = −12288.
   - WRAP=0 (second instance): d0 = +53248, vector_x = vector_y = 53248.
3. **Masking.** Scenario 1 inputs with mask=3'b001.
   - vector_x = 409600, vector_y = 0.
   - phase_differences are still {4096, 0, −4096}.
   - mask=0 gives a zero vector.
4. **Back-pressure and busy.** Hold ready_in=0 for 5 cycles in DONE and pulse valid_in with new data during CALC and DONE.
   - Outputs stay constant and valid_out stays 1.
   - The pulses during CALC/DONE are not captured.
   - Raising ready_in gives valid_out=0 and ready_out=1 on the next edge.
5. **Reset mid-operation.** Drop rst_n_in asynchronously (not clock-aligned) during the second CALC cycle.
   - All outputs reach reset values without waiting for a clock edge.
   - After release, a fresh scenario-1 run yields exactly the scenario-1 results.
6. **Back-to-back transactions.** valid_in held high and ready_in held high.
   - Accepts occur every 5 cycles.
   - Each valid_out pulse lasts exactly 1 cycle with correct per-snapshot results.
